// File: rtl/keypad_matrix_scanner.sv
// COLSxROWS keypad scanner: one active-low column strobe per DWELL cycles, frame-level debounce, one key-press event per frame.
// Latency: o_key_map updates 2 cycles after the last column's sample and o_key_valid follows 1 cycle later. The outputs have no backpressure.
module keypad_matrix_scanner #(
    parameter int COLS     = 3,
    parameter int ROWS     = 4,
    parameter int DWELL    = 1000,
    parameter int DEBOUNCE = 4,
    localparam int KW      = $clog2(ROWS*COLS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS-1:0]      i_rows,
    output logic [COLS-1:0]      o_cols,
    output logic                 o_key_valid,
    output logic [KW-1:0]        o_key_code,
    output logic [ROWS*COLS-1:0] o_key_map,
    output logic                 o_any_pressed
);

    localparam int NK = ROWS * COLS;
    localparam int CW = $clog2(COLS);
    localparam int DW = $clog2(DWELL);
    localparam int SW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [ROWS-1:0] sync1_q, sync2_q;
    logic [CW-1:0]   col_q, col_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [COLS-1:0] cols_q, cols_d;
    logic [NK-1:0]   frame_cur_q, frame_cur_d;
    logic [NK-1:0]   frame_prev_q, frame_prev_d;
    logic [NK-1:0]   key_map_q, key_map_d;
    logic [NK-1:0]   reported_q, reported_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic            eof_q, eof_d;
    logic            evt_q;
    logic            key_valid_q, key_valid_d;
    logic [KW-1:0]   key_code_q, key_code_d;

    logic            sample;
    logic [NK-1:0]   pending;
    logic [KW-1:0]   low_idx;

    assign sample  = (dwell_q == DW'(DWELL - 1));
    assign pending = key_map_q & ~reported_q;

    // Column scan and per-column capture into the frame being assembled.
    always_comb begin
        dwell_d     = sample ? '0 : dwell_q + DW'(1);
        col_d       = col_q;
        cols_d      = cols_q;
        frame_cur_d = frame_cur_q;
        eof_d       = sample && (col_q == CW'(COLS - 1));
        if (sample) begin
            col_d  = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
            cols_d = ~(COLS'(1) << col_d);
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (CW'(c) == col_q) begin
                        frame_cur_d[r*COLS + c] = sync2_q[r];
                    end
                end
            end
        end
    end

    // Debounce: the frame is accepted once DEBOUNCE identical frames have been seen in a row.
    always_comb begin
        stable_d     = stable_q;
        frame_prev_d = frame_prev_q;
        key_map_d    = key_map_q;
        if (eof_q) begin
            if (frame_cur_q == frame_prev_q) begin
                stable_d = (stable_q == SW'(DEBOUNCE - 1)) ? stable_q : stable_q + SW'(1);
            end else begin
                stable_d = '0;
            end
            frame_prev_d = frame_cur_q;
            if (stable_d == SW'(DEBOUNCE - 1)) begin
                key_map_d = frame_cur_q;
            end
        end
    end

    always_comb begin
        low_idx = '0;
        for (int i = NK - 1; i >= 0; i--) begin
            if (pending[i]) begin
                low_idx = KW'(i);
            end
        end
    end

    // Released keys forget their reported state, so a later re-press reports again.
    always_comb begin
        reported_d  = reported_q & key_map_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (evt_q && (|pending)) begin
            key_valid_d = 1'b1;
            key_code_d  = low_idx;
            reported_d  = reported_d | (NK'(1) << low_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            col_q        <= '0;
            dwell_q      <= '0;
            cols_q       <= ~COLS'(1);
            frame_cur_q  <= '0;
            frame_prev_q <= '0;
            key_map_q    <= '0;
            reported_q   <= '0;
            stable_q     <= '0;
            eof_q        <= 1'b0;
            evt_q        <= 1'b0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
        end else begin
            sync1_q      <= ~i_rows;
            sync2_q      <= sync1_q;
            col_q        <= col_d;
            dwell_q      <= dwell_d;
            cols_q       <= cols_d;
            frame_cur_q  <= frame_cur_d;
            frame_prev_q <= frame_prev_d;
            key_map_q    <= key_map_d;
            reported_q   <= reported_d;
            stable_q     <= stable_d;
            eof_q        <= eof_d;
            evt_q        <= eof_q;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
        end
    end

    assign o_cols        = cols_q;
    assign o_key_valid   = key_valid_q;
    assign o_key_code    = key_code_q;
    assign o_key_map     = key_map_q;
    assign o_any_pressed = |key_map_q;

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised row/column keypad scanner with debounce and key-event output. Drives one active-low column strobe at a time with a programmable dwell, samples the active-low row lines through a synchroniser, assembles a full key bitmap per frame, debounces it across frames and emits one registered key-press event per frame. Sits between the keypad pins and the command/decoder logic, and generalises the fixed 3-column cyclic column driver to any COLS×ROWS matrix.

## Interface
- COLS, 3, number of driven column lines (≥2)
- ROWS, 4, number of sensed row lines (≥1)
- DWELL, 1000, clock cycles each column stays driven (≥4)
- DEBOUNCE, 4, consecutive identical frames required to accept a new bitmap (≥1)
- KW, $clog2(ROWS*COLS), key code width (derived, not overridden)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_rows  in  ROWS  row lines, active-low (0 = key closed on driven column), asynchronous
- o_cols  out  COLS  column strobes, active-low, exactly one bit low at all times
- o_key_valid  out  1  one-cycle pulse, new key press reported
- o_key_code  out  KW  pressed key index = row*COLS + col, held until next event
- o_key_map  out  ROWS*COLS  debounced bitmap, bit row*COLS+col, 1 = pressed
- o_any_pressed  out  1  OR of o_key_map

## Operation
- i_rows passes a 2-flop synchroniser; all sampling uses the synchronised, inverted value (1 = pressed).
- Column counter col 0..COLS-1, dwell counter 0..DWELL-1. o_cols = ~(1<<col), registered.
- Sample cycle: dwell == DWELL-1. Row bits written into frame_cur at positions r*COLS+col. Dwell wraps to 0, col advances; col COLS-1 wraps to 0.
- End of frame (sample with col == COLS-1): frame_cur compared with frame_prev; equal → stable_cnt = min(stable_cnt+1, DEBOUNCE-1), different → stable_cnt = 0; frame_prev <= frame_cur.
- When stable_cnt == DEBOUNCE-1 after update, o_key_map <= frame_cur. DEBOUNCE=1 accepts every frame.
- Reported mask: bit clears whenever its o_key_map bit is 0. pending = o_key_map & ~reported.
- Once per frame, at event slot: if pending ≠ 0, emit lowest-index pending bit on o_key_code, pulse o_key_valid, set its reported bit. Remaining pending keys report in following frames, one per frame.
- Key released before being reported: its pending bit vanishes, no event.
- Held key: single event only; re-press after accepted release produces new event.
- Releases produce no event; visible only on o_key_map.

## Timing
- Reset values: col 0, dwell 0, o_cols = all ones except bit 0 low, synchroniser/frame_cur/frame_prev/o_key_map/reported 0, stable_cnt 0, o_key_valid 0, o_key_code 0, o_any_pressed 0.
- First cycle after rst deasserts: column 0 driven with full DWELL cycles.
- Column period DWELL cycles; frame period COLS*DWELL cycles; o_cols changes the cycle after each sample cycle.
- Row change visible in sample ≥2 cycles after it settles on i_rows (synchroniser).
- Let T = final-column sample cycle: o_key_map updates in cycle T+2, o_key_valid high in cycle T+3 only, o_key_code valid from T+3.
- Minimum press-to-event: DEBOUNCE frames of identical bitmap + 3 cycles.
- rst mid-frame: all state to reset values next edge; partial frame discarded; no o_key_valid during or the cycle after rst.

## Test plan
- Reset: hold rst 3 cycles mid-scan → o_cols=...110, o_key_valid=0, o_key_map=0; column 0 then held exactly DWELL cycles.
- Rotation (COLS=3, DWELL=8): no keys → o_cols sequence 110,101,011 each 8 cycles, repeating; never two bits low; no events.
- Single press (ROWS=4, DEBOUNCE=3): hold row 1 low while column 2 driven → one o_key_valid pulse, o_key_code=5, o_key_map bit 5 set; holding 10 more frames → no further pulse.
- Bounce: toggle row 1/col 2 every frame for 5 frames then stable → no event until 3 identical frames, then exactly one event code 5.
- Two simultaneous keys (codes 1 and 10) → events code 1 then code 10 in consecutive frames; release both → o_key_map=0, o_any_pressed=0, no events.
- Short glitch: row low for one dwell only → o_key_map unchanged, no event.
